// File: rtl/seg_p2s_pkg.sv
// Shared types for the seven-segment serial link.
// Frame width default and transmitter state encoding.
package seg_pkg;

  localparam int SEG_FRAME_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI
  } seg_p2s_state_t;

endpackage

// File: rtl/seg_p2s_if.sv
// Start/data request and busy/done status bundle
// between the display-data mux and the transmitter.
interface seg_p2s_if #(
  parameter int DATA_W = 64
) ();

  logic              start;
  logic [DATA_W-1:0] pdata;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output pdata,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  pdata,
    output busy,
    output done
  );

endinterface

// File: rtl/seg_p2s_sclk_gen.sv
// Serial clock divider: flags the last clk cycle
// of each sclk half-period.
module seg_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic half_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] divcnt;

  assign half_tick = (divcnt == LAST);

  // Count clk cycles within a half-period; wrap on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divcnt <= '0;
    end else if (load) begin
      divcnt <= '0;
    end else if (en) begin
      divcnt <= half_tick ? '0 : divcnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_p2s.sv
// Parallel-to-serial transmitter for the shift-register
// seven-segment display; MSB first on a divided sclk.
module seg_p2s
  import seg_pkg::*;
#(
  parameter int DATA_W  = SEG_FRAME_W,
  parameter int CLK_DIV = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_p2s_if.slave  bus,
  output logic      sclk,
  output logic      sdout,
  output logic      sclrn,
  output logic      pen
);

  localparam int BW = $clog2(DATA_W);

  seg_p2s_state_t    state;
  logic [DATA_W-2:0] shreg;
  logic [BW-1:0]     bitcnt;
  logic              busy_q;
  logic              done_q;
  logic              load;
  logic              half_tick;

  assign load     = (state == IDLE) && bus.start;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  seg_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .en        (state != IDLE),
    .half_tick (half_tick)
  );

  // Frame FSM; the MSB goes straight to sdout at load,
  // so shreg only holds the bits still to come.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sclk   <= 1'b0;
      sdout  <= 1'b0;
      sclrn  <= 1'b0;
      pen    <= 1'b0;
    end else begin
      sclrn  <= 1'b1;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            shreg  <= bus.pdata[DATA_W-2:0];
            sdout  <= bus.pdata[DATA_W-1];
            bitcnt <= BW'(DATA_W - 1);
            busy_q <= 1'b1;
            pen    <= 1'b0;
            state  <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (half_tick) begin
            sclk  <= 1'b1;
            state <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (half_tick) begin
            sclk <= 1'b0;
            if (bitcnt != '0) begin
              sdout  <= shreg[DATA_W-2];
              shreg  <= shreg << 1;
              bitcnt <= bitcnt - BW'(1);
              state  <= SHIFT_LO;
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pen    <= 1'b1;
              sdout  <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_p2s.sv
// Bench for seg_p2s: 64-bit/div-2 and 8-bit/div-1
// instances checked against a frame-level model.
module tb_seg_p2s;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_p2s_if #(.DATA_W(64)) b0 ();
  seg_p2s_if #(.DATA_W(8))  b1 ();

  logic sclk0, sdout0, sclrn0, pen0;
  logic sclk1, sdout1, sclrn1, pen1;

  seg_p2s #(.DATA_W(64), .CLK_DIV(2)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0),
    .sclk  (sclk0),
    .sdout (sdout0),
    .sclrn (sclrn0),
    .pen   (pen0)
  );

  seg_p2s #(.DATA_W(8), .CLK_DIV(1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1),
    .sclk  (sclk1),
    .sdout (sdout1),
    .sclrn (sclrn1),
    .pen   (pen1)
  );

  int total = 0;
  int bad = 0;

  int   edge0 = 0;
  int   rise0[$];
  int   acc0[$];
  int   don0[$];
  logic bits0[$];
  logic dpen0[$];
  logic dppen0[$];
  logic dbusy0[$];
  logic psclk0 = 1'b0;
  logic pbusy0 = 1'b0;
  logic ppen0 = 1'b0;

  int   edge1 = 0;
  int   rise1[$];
  int   acc1[$];
  int   don1[$];
  logic bits1[$];
  logic psclk1 = 1'b0;
  logic pbusy1 = 1'b0;

  // Observe each instance just after every rising edge.
  always @(posedge clk) begin
    #1;
    edge0++;
    if (sclk0 && !psclk0) begin
      bits0.push_back(sdout0);
      rise0.push_back(edge0);
    end
    if (b0.busy && !pbusy0) acc0.push_back(edge0);
    if (b0.done) begin
      don0.push_back(edge0);
      dpen0.push_back(pen0);
      dppen0.push_back(ppen0);
      dbusy0.push_back(b0.busy);
    end
    psclk0 = sclk0;
    pbusy0 = b0.busy;
    ppen0 = pen0;
  end

  always @(posedge clk) begin
    #1;
    edge1++;
    if (sclk1 && !psclk1) begin
      bits1.push_back(sdout1);
      rise1.push_back(edge1);
    end
    if (b1.busy && !pbusy1) acc1.push_back(edge1);
    if (b1.done) don1.push_back(edge1);
    psclk1 = sclk1;
    pbusy1 = b1.busy;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr0();
    rise0.delete(); acc0.delete(); don0.delete(); bits0.delete();
    dpen0.delete(); dppen0.delete(); dbusy0.delete();
  endtask

  task automatic clr1();
    rise1.delete(); acc1.delete(); don1.delete(); bits1.delete();
  endtask

  task automatic wait_done0(input string tag, input int n_done,
                            input int lim);
    int n = 0;
    while (don0.size() < n_done && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(don0.size() >= n_done), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_done1(input string tag, input int lim);
    int n = 0;
    while (don1.size() == 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(don1.size() != 0), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  // One 64-bit frame: serial stream, bit timing, length, pen.
  task automatic check_frame0(input string tag, input logic [63:0] d);
    logic [63:0] v = '0;
    logic        ok = 1'b1;
    chk({tag, "_nrise"}, 64'(bits0.size()), 64'd64);
    for (int i = 0; i < bits0.size() && i < 64; i++)
      v = {v[62:0], bits0[i]};
    chk({tag, "_data"}, v, d);
    chk({tag, "_ndone"}, 64'(don0.size()), 64'd1);
    if (acc0.size() > 0 && don0.size() > 0) begin
      chk({tag, "_len"}, 64'(don0[0] - acc0[0]), 64'd256);
      for (int i = 0; i < rise0.size(); i++)
        if (rise0[i] != acc0[0] + 2 * (2 * i + 1)) ok = 1'b0;
      chk({tag, "_timing"}, 64'(ok), 64'd1);
      chk({tag, "_pen_busy"}, {61'd0, dppen0[0], dpen0[0], dbusy0[0]},
          64'b010);
    end
  endtask

  task automatic send0(input logic [63:0] d);
    @(negedge clk);
    b0.pdata = d;
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
  endtask

  task automatic frame1(input string tag, input logic [7:0] d);
    logic [7:0] v = '0;
    logic       ok = 1'b1;
    clr1();
    @(negedge clk);
    b1.pdata = d;
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    wait_done1(tag, 100);
    chk({tag, "_nrise"}, 64'(bits1.size()), 64'd8);
    for (int i = 0; i < bits1.size() && i < 8; i++)
      v = {v[6:0], bits1[i]};
    chk({tag, "_data"}, 64'(v), 64'(d));
    if (acc1.size() > 0 && don1.size() > 0) begin
      chk({tag, "_len"}, 64'(don1[0] - acc1[0]), 64'd16);
      for (int i = 0; i < rise1.size(); i++)
        if (rise1[i] != acc1[0] + 2 * i + 1) ok = 1'b0;
      chk({tag, "_timing"}, 64'(ok), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] v;
    b0.start = 1'b0;
    b0.pdata = '0;
    b1.start = 1'b0;
    b1.pdata = '0;

    // Reset values and sclrn release
    repeat (3) @(negedge clk);
    chk("rst0", {58'd0, b0.busy, b0.done, sclk0, sdout0, sclrn0, pen0},
        64'd0);
    chk("rst1", {58'd0, b1.busy, b1.done, sclk1, sdout1, sclrn1, pen1},
        64'd0);
    rst_n = 1'b1;
    #1;
    chk("sclrn_hold", 64'(sclrn0), 64'd0);
    @(negedge clk);
    chk("sclrn_rise", {62'd0, sclrn0, sclrn1}, 64'b11);
    chk("idle_out", {61'd0, pen0, sclk0, b0.busy}, 64'd0);

    // Frame with only end bits set
    clr0();
    send0(64'h8000_0000_0000_0001);
    wait_done0("A", 1, 400);
    check_frame0("A", 64'h8000_0000_0000_0001);

    // pdata changes after capture must not leak in
    clr0();
    send0(64'hA5A5_5A5A_0F0F_F0F0);
    @(negedge clk);
    b0.pdata = '1;
    wait_done0("B", 1, 400);
    check_frame0("B", 64'hA5A5_5A5A_0F0F_F0F0);

    // Random frames
    for (int r = 0; r < 3; r++) begin
      d = {$urandom, $urandom};
      clr0();
      send0(d);
      wait_done0($sformatf("R%0d", r), 1, 400);
      check_frame0($sformatf("R%0d", r), d);
    end

    // start mid-frame is ignored
    clr0();
    d = {$urandom, $urandom};
    send0(d);
    repeat (98) @(negedge clk);
    b0.pdata = ~d;
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    chk("ign_busy", 64'(b0.busy), 64'd1);
    wait_done0("ign", 1, 400);
    check_frame0("ign", d);

    // start held: back-to-back frames
    clr0();
    @(negedge clk);
    b0.pdata = 64'h1;
    b0.start = 1'b1;
    repeat (300) @(negedge clk);
    b0.start = 1'b0;
    wait_done0("held", 2, 400);
    chk("held_nacc", 64'(acc0.size()), 64'd2);
    chk("held_ndone", 64'(don0.size()), 64'd2);
    chk("held_nrise", 64'(bits0.size()), 64'd128);
    if (acc0.size() == 2 && don0.size() == 2) begin
      chk("held_len1", 64'(don0[0] - acc0[0]), 64'd256);
      chk("held_b2b", 64'(acc0[1] - don0[0]), 64'd1);
      chk("held_len2", 64'(don0[1] - acc0[1]), 64'd256);
    end
    if (bits0.size() == 128) begin
      v = '0;
      for (int i = 64; i < 128; i++) v = {v[62:0], bits0[i]};
      chk("held_f2_first", 64'(bits0[64]), 64'd0);
      chk("held_f2_data", v, 64'h1);
    end

    // Asynchronous reset mid-frame
    clr0();
    send0(64'hFFFF_0000_FFFF_0000);
    repeat (76) @(negedge clk);
    chk("mid_busy", 64'(b0.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst",
        {58'd0, b0.busy, b0.done, sclk0, sdout0, sclrn0, pen0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clr0();
    repeat (300) @(negedge clk);
    chk("post_rst_nosclk", 64'(rise0.size()), 64'd0);
    chk("post_rst_state", {61'd0, sclrn0, pen0, b0.busy}, 64'b100);

    // Narrow, undivided instance
    frame1("N", 8'hC3);
    frame1("NR", 8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
